ptmch_trg_cnt_array: RTL and testbench

//  Parametrised N-channel trigger-pulse event counter for the ptmch flash-command monitor.

---
 rtl/ptmch_trg_cnt_array.sv | 117 +++++++++++
 tb/tb_ptmch_trg_cnt_array.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_trg_cnt_array.sv
// N-channel trigger-pulse event counter: sync -> glitch filter -> rise detect -> counter,
// with sticky overflow, a coherent snapshot bank and a selectable page-address feed.
`timescale 1ns/1ps
module ptmch_trg_cnt_array #(
   parameter int NCH      = 5,
   parameter int CW       = 32,
   parameter int SYNC_STG = 3,
   parameter int FILT_LEN = 2,
   parameter int PA_W     = 9,
   parameter int SEL_W    = 3
) (
   input  logic             CLK100M,
   input  logic             RESET_N,
   input  logic [NCH-1:0]   TRG_PLS,
   input  logic [NCH-1:0]   CNT_EN,
   input  logic [NCH-1:0]   CNT_CLR,
   input  logic             SAT_MODE,
   input  logic             SNAP_REQ,
   input  logic [SEL_W-1:0] CNT_RD_SEL,
   output logic [CW-1:0]    CNT_RD_DATA,
   output logic [NCH-1:0]   OVF,
   input  logic [SEL_W-1:0] PAGEADDR_SEL,
   output logic [PA_W-1:0]  PADDR_CNT,
   output logic             PLS_RISE
);

   logic [SYNC_STG-1:0] sync_q [NCH];
   logic [FILT_LEN-1:0] hist_q [NCH];
   logic [CW-1:0]       cnt_q  [NCH];
   logic [CW-1:0]       snap_q [NCH];
   logic [NCH-1:0]      filt_q;
   logic [NCH-1:0]      filt_d_q;
   logic [NCH-1:0]      rise;
   logic [NCH-1:0]      rise_q;
   logic [NCH-1:0]      ovf_q;
   logic [SEL_W-1:0]    page_sel;
   logic [SEL_W-1:0]    rd_sel;
   logic                rd_sel_ok;

   assign rise = filt_q & ~filt_d_q;
   assign OVF  = ovf_q;

   // Out-of-range selects: page feed falls back to channel 0, snapshot read returns 0.
   always_comb begin
      page_sel  = PAGEADDR_SEL;
      rd_sel    = CNT_RD_SEL;
      rd_sel_ok = 1'b1;
      if (32'(PAGEADDR_SEL) >= NCH) page_sel = '0;
      if (32'(CNT_RD_SEL) >= NCH) begin
         rd_sel    = '0;
         rd_sel_ok = 1'b0;
      end
   end

   // Filtered level only moves when the whole history agrees; mixed history holds it.
   always_ff @(posedge CLK100M) begin
      if (!RESET_N) begin
         for (int i = 0; i < NCH; i++) begin
            sync_q[i] <= '0;
            hist_q[i] <= '0;
         end
         filt_q   <= '0;
         filt_d_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            sync_q[i] <= SYNC_STG'({sync_q[i], TRG_PLS[i]});
            hist_q[i] <= FILT_LEN'({hist_q[i], sync_q[i][SYNC_STG-1]});
            if (&hist_q[i])
               filt_q[i] <= 1'b1;
            else if (~|hist_q[i])
               filt_q[i] <= 1'b0;
         end
         filt_d_q <= filt_q;
      end
   end

   // Clear beats a coincident rise; snapshot copies the pre-update live value.
   always_ff @(posedge CLK100M) begin
      if (!RESET_N) begin
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (SNAP_REQ) snap_q[i] <= cnt_q[i];
            if (CNT_CLR[i]) begin
               cnt_q[i] <= '0;
               ovf_q[i] <= 1'b0;
            end else if (rise[i] && CNT_EN[i]) begin
               if (cnt_q[i] == {CW{1'b1}}) begin
                  ovf_q[i] <= 1'b1;
                  if (!SAT_MODE) cnt_q[i] <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge CLK100M) begin
      if (!RESET_N) begin
         rise_q      <= '0;
         PLS_RISE    <= 1'b0;
         PADDR_CNT   <= '0;
         CNT_RD_DATA <= '0;
      end else begin
         rise_q      <= rise;
         PLS_RISE    <= rise_q[page_sel];
         PADDR_CNT   <= cnt_q[page_sel][PA_W-1:0];
         CNT_RD_DATA <= rd_sel_ok ? snap_q[rd_sel] : '0;
      end
   end

endmodule

// File: tb/tb_ptmch_trg_cnt_array.sv
// Bench for ptmch_trg_cnt_array: a default instance and a narrow CW=4 instance share stimulus;
// expectations are queued with a due cycle and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ptmch_trg_cnt_array;

   localparam int S_PA_B   = 0;
   localparam int S_RISE_B = 1;
   localparam int S_RD_B   = 2;
   localparam int S_OVF_B  = 3;
   localparam int S_PA_S   = 4;
   localparam int S_OVF_S  = 5;
   localparam int S_RD_S   = 6;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  trg_pls, cnt_en, cnt_clr;
   logic        sat_mode, snap_req;
   logic [2:0]  cnt_rd_sel, pageaddr_sel;

   logic [31:0] rd_data_b;
   logic [4:0]  ovf_b;
   logic [8:0]  paddr_b;
   logic        rise_b;
   logic [3:0]  rd_data_s;
   logic [4:0]  ovf_s;
   logic [3:0]  paddr_s;
   logic        rise_s;

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int          due;
      int          sig;
      logic [31:0] exp;
      string       name;
   } chk_t;
   chk_t        exp_q[$];
   chk_t        mon_c;
   logic [31:0] mon_act;

   ptmch_trg_cnt_array u_big (
      .CLK100M(clk), .RESET_N(reset_n), .TRG_PLS(trg_pls), .CNT_EN(cnt_en),
      .CNT_CLR(cnt_clr), .SAT_MODE(sat_mode), .SNAP_REQ(snap_req),
      .CNT_RD_SEL(cnt_rd_sel), .CNT_RD_DATA(rd_data_b), .OVF(ovf_b),
      .PAGEADDR_SEL(pageaddr_sel), .PADDR_CNT(paddr_b), .PLS_RISE(rise_b)
   );

   ptmch_trg_cnt_array #(.CW(4), .PA_W(4)) u_small (
      .CLK100M(clk), .RESET_N(reset_n), .TRG_PLS(trg_pls), .CNT_EN(cnt_en),
      .CNT_CLR(cnt_clr), .SAT_MODE(sat_mode), .SNAP_REQ(snap_req),
      .CNT_RD_SEL(cnt_rd_sel), .CNT_RD_DATA(rd_data_s), .OVF(ovf_s),
      .PAGEADDR_SEL(pageaddr_sel), .PADDR_CNT(paddr_s), .PLS_RISE(rise_s)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   function automatic logic [31:0] observe(int sig);
      case (sig)
         S_PA_B:   return {23'd0, paddr_b};
         S_RISE_B: return {31'd0, rise_b};
         S_RD_B:   return rd_data_b;
         S_OVF_B:  return {27'd0, ovf_b};
         S_PA_S:   return {28'd0, paddr_s};
         S_OVF_S:  return {27'd0, ovf_s};
         S_RD_S:   return {28'd0, rd_data_s};
         default:  return 32'hdead_beef;
      endcase
   endfunction

   // Queue kept sorted by due cycle so the monitor only inspects the head.
   task automatic push_exp(input int dly, input int sig, input logic [31:0] exp, input string name);
      chk_t c;
      int   pos;
      c.due  = cyc + dly;
      c.sig  = sig;
      c.exp  = exp;
      c.name = name;
      pos = exp_q.size();
      while (pos > 0 && exp_q[pos-1].due > c.due) pos--;
      exp_q.insert(pos, c);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         mon_c   = exp_q.pop_front();
         mon_act = observe(mon_c.sig);
         n_chk++;
         if (mon_c.due < cyc)
            $display("FAIL %s: sampled late at cycle %0d, required cycle %0d", mon_c.name, cyc, mon_c.due);
         else if (mon_act !== mon_c.exp)
            $display("FAIL %s: cycle %0d got 0x%0h required 0x%0h", mon_c.name, cyc, mon_act, mon_c.exp);
         else
            n_pass++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input logic [4:0] mask, input int hi, input int lo);
      trg_pls = trg_pls | mask;
      ticks(hi);
      trg_pls = trg_pls & ~mask;
      ticks(lo);
   endtask

   task automatic clr(input logic [4:0] mask);
      cnt_clr = mask;
      tick();
      cnt_clr = '0;
   endtask

   task automatic snap();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
   endtask

   task automatic rd(input logic [2:0] ch, input logic [31:0] exp_b, input logic [31:0] exp_s, input string name);
      cnt_rd_sel = ch;
      push_exp(1, S_RD_B, exp_b, name);
      push_exp(1, S_RD_S, exp_s, name);
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n      = 1'b0;
      trg_pls      = 5'h1f;
      cnt_en       = 5'h1f;
      cnt_clr      = '0;
      sat_mode     = 1'b0;
      snap_req     = 1'b0;
      cnt_rd_sel   = '0;
      pageaddr_sel = '0;
      ticks(3);

      // Reset with all triggers high: every output is zero
      push_exp(0, S_PA_B,   0, "rst_paddr");
      push_exp(0, S_RISE_B, 0, "rst_rise");
      push_exp(0, S_RD_B,   0, "rst_rd");
      push_exp(0, S_OVF_B,  0, "rst_ovf");
      push_exp(0, S_PA_S,   0, "rst_paddr_s");
      push_exp(0, S_OVF_S,  0, "rst_ovf_s");

      // Release: level already high counts once, counter at edge 7, outputs at edge 8
      reset_n = 1'b1;
      push_exp(7, S_PA_B,   0, "rst_lat_pre");
      push_exp(8, S_PA_B,   1, "rst_lat_cnt");
      push_exp(8, S_PA_S,   1, "rst_lat_cnt_s");
      push_exp(8, S_RISE_B, 1, "rst_rise_edge");
      ticks(10);
      trg_pls = '0;
      snap();
      for (int ch = 0; ch < 5; ch++) rd(3'(ch), 1, 1, "rst_all_ch");
      clr(5'h1f);
      ticks(12);

      // Latency and one-cycle strobe on ch0
      trg_pls[0] = 1'b1;
      push_exp(7, S_PA_B,   0, "lat_pre");
      push_exp(8, S_PA_B,   1, "lat_cnt");
      push_exp(7, S_RISE_B, 0, "rise_pre");
      push_exp(8, S_RISE_B, 1, "rise_edge");
      push_exp(9, S_RISE_B, 0, "rise_width");
      ticks(10);
      trg_pls[0] = 1'b0;
      ticks(10);

      // Single-cycle glitch is filtered out
      trg_pls[0] = 1'b1;
      push_exp(8, S_RISE_B, 0, "glitch_rise");
      tick();
      trg_pls[0] = 1'b0;
      ticks(12);
      push_exp(0, S_PA_B, 1, "glitch_cnt");

      // Wrap on the CW=4 instance
      clr(5'h1f);
      sat_mode = 1'b0;
      repeat (15) pulse(5'h01, 3, 3);
      ticks(8);
      push_exp(0, S_PA_S,  15, "wrap_15");
      push_exp(0, S_OVF_S, 0,  "wrap_ovf_pre");
      pulse(5'h01, 3, 3);
      ticks(8);
      push_exp(0, S_PA_S,  0,  "wrap_cnt");
      push_exp(0, S_OVF_S, 1,  "wrap_ovf");
      push_exp(0, S_PA_B,  16, "big_16");
      push_exp(0, S_OVF_B, 0,  "big_no_ovf");

      // Saturate, then clear drops count and overflow
      clr(5'h01);
      sat_mode = 1'b1;
      repeat (16) pulse(5'h01, 3, 3);
      ticks(8);
      push_exp(0, S_PA_S,  15, "sat_cnt");
      push_exp(0, S_OVF_S, 1,  "sat_ovf");
      cnt_clr = 5'h01;
      tick();
      cnt_clr = '0;
      push_exp(0, S_OVF_S, 0, "clr_ovf");
      push_exp(1, S_PA_S,  0, "clr_cnt");
      ticks(2);
      sat_mode = 1'b0;

      // Clear on the increment edge wins over the rise
      pulse(5'h01, 3, 3);
      ticks(8);
      push_exp(0, S_PA_S, 1, "pre_clr_rise");
      trg_pls[0] = 1'b1;
      push_exp(7, S_PA_S, 1, "clr_rise_pre");
      push_exp(8, S_PA_S, 0, "clr_rise");
      ticks(6);
      cnt_clr = 5'h01;
      tick();
      cnt_clr = '0;
      ticks(2);
      trg_pls[0] = 1'b0;
      ticks(10);

      // Disabled channel ignores rises
      pulse(5'h01, 3, 3);
      ticks(8);
      push_exp(0, S_PA_S, 1, "en_pre");
      cnt_en[0] = 1'b0;
      repeat (3) pulse(5'h01, 3, 3);
      ticks(8);
      push_exp(0, S_PA_S, 1, "en_hold");
      cnt_en[0] = 1'b1;

      // Snapshot coincident with a rise on ch2
      clr(5'h1f);
      repeat (7) pulse(5'h04, 3, 3);
      ticks(8);
      trg_pls[2] = 1'b1;
      ticks(6);
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      ticks(4);
      trg_pls[2] = 1'b0;
      ticks(6);
      rd(3'd2, 7, 7, "snap_coinc");
      rd(3'd7, 0, 0, "rd_oob7");
      rd(3'd5, 0, 0, "rd_oob5");
      rd(3'd0, 0, 0, "snap_ch0");
      pageaddr_sel = 3'd2;
      push_exp(1, S_PA_B, 8, "live_ch2");
      push_exp(1, S_PA_S, 8, "live_ch2_s");
      tick();

      // Page select: ch3 = 0x205, ch0 = 3 (first three rises shared)
      pageaddr_sel = 3'd0;
      clr(5'h1f);
      repeat (3) pulse(5'h09, 3, 3);
      repeat (514) pulse(5'h08, 3, 3);
      ticks(8);
      pageaddr_sel = 3'd3;
      push_exp(1, S_PA_B, 9'h005, "page_sel3");
      push_exp(1, S_PA_S, 5,      "page_sel3_s");
      tick();
      pageaddr_sel = 3'd6;
      push_exp(0, S_PA_B, 9'h005, "sel_change_delay");
      push_exp(1, S_PA_B, 3,      "page_oob");
      tick();
      pageaddr_sel = 3'd0;
      push_exp(1, S_PA_B, 3, "page_ch0");
      tick();
      snap();
      rd(3'd3, 32'h205, 5, "snap_517");
      rd(3'd0, 3, 3, "snap_ch0_3");

      // ---------------- final report ----------------
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      if (exp_q.size() > 0) begin
         $display("FAIL drain: %0d expectations never sampled, required 0", exp_q.size());
         n_chk = n_chk + exp_q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
